// File: rtl/sysray_deskew_acc_if.sv
`default_nettype none
// ============================================================================
// Module      : sysray_deskew_acc_if
// Description : Psum input bus and writeback output handshake of the
//               systolic-array deskew/accumulate stage.
// Revision    : 1.0 - initial release
// ============================================================================
interface sysray_deskew_acc_if #(
  parameter int N         = 4,
  parameter int ACC_WIDTH = 32,
  parameter int ROWS      = 16
);
  logic [N*ACC_WIDTH-1:0]  psum_i;
  logic                    psum_valid_i;
  logic [$clog2(ROWS)-1:0] row_i;
  logic                    first_i;
  logic                    last_i;
  logic [N*ACC_WIDTH-1:0]  out_data_o;
  logic                    out_valid_o;
  logic                    out_ready_i;

  // Driver side: the array feeding psums and the writeback consumer
  modport master (
    output psum_i, psum_valid_i, row_i, first_i, last_i, out_ready_i,
    input  out_data_o, out_valid_o
  );

  // Design side
  modport slave (
    input  psum_i, psum_valid_i, row_i, first_i, last_i, out_ready_i,
    output out_data_o, out_valid_o
  );
endinterface
`default_nettype wire

// File: rtl/sysray_deskew_acc.sv
`default_nettype none
// ============================================================================
// Module      : sysray_deskew_acc
// Description : Deskews the column-staggered psum vector leaving the systolic
//               array, accumulates aligned vectors across K-tiles into a row
//               bank, and queues finished rows in a FWFT output FIFO.
//               Requires N >= 2 and FIFO_DEPTH a power of two >= 2.
// Revision    : 1.0 - initial release
// ============================================================================
module sysray_deskew_acc #(
  parameter int N          = 4,
  parameter int ACC_WIDTH  = 32,
  parameter int ROWS       = 16,
  parameter int FIFO_DEPTH = 4
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  sysray_deskew_acc_if.slave bus,
  output logic               busy_o,
  output logic               overflow_o
);

  localparam int c_VW = N * ACC_WIDTH;
  localparam int c_RW = $clog2(ROWS);
  localparam int c_PW = $clog2(FIFO_DEPTH);
  localparam int c_CW = c_PW + 1;
  localparam logic [c_CW-1:0] c_FULL = c_CW'(FIFO_DEPTH);

  typedef struct packed {
    logic            vld;
    logic [c_RW-1:0] row;
    logic            first;
    logic            last;
  } ctl_t;

  // Control travels alongside lane 0, which has the longest delay (N-1)
  ctl_t            r_ctl [N-1];
  ctl_t            w_ctl_in;
  ctl_t            w_al;
  logic            w_pipe_any;

  logic [c_VW-1:0] w_aligned;
  logic [c_VW-1:0] w_acc_cur;
  logic [c_VW-1:0] w_acc_new;
  logic [c_VW-1:0] r_acc [ROWS];

  logic [c_VW-1:0] r_fifo [FIFO_DEPTH];
  logic [c_PW-1:0] r_wptr;
  logic [c_PW-1:0] r_rptr;
  logic [c_CW-1:0] r_count;
  logic            r_ovf;
  logic            w_push_req;
  logic            w_push;
  logic            w_pop;
  logic            w_full;
  logic            w_drop;

  assign w_ctl_in = '{vld: bus.psum_valid_i, row: bus.row_i,
                      first: bus.first_i, last: bus.last_i};
  assign w_al     = r_ctl[N-2];

  // Control delay line: N-1 stages so it lines up with the deskewed lanes
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < N-1; i++) r_ctl[i] <= '0;
    end else begin
      r_ctl[0] <= w_ctl_in;
      for (int i = 1; i < N-1; i++) r_ctl[i] <= r_ctl[i-1];
    end
  end

  // Any vector still travelling through the deskew pipe
  always_comb begin
    w_pipe_any = 1'b0;
    for (int i = 0; i < N-1; i++) w_pipe_any = w_pipe_any | r_ctl[i].vld;
  end

  assign w_acc_cur = r_acc[w_al.row];

  for (genvar c = 0; c < N; c++) begin : g_lane
    localparam int c_D = N - 1 - c;
    if (c_D == 0) begin : g_pass
      assign w_aligned[c*ACC_WIDTH +: ACC_WIDTH] = bus.psum_i[c*ACC_WIDTH +: ACC_WIDTH];
    end else begin : g_dly
      logic [ACC_WIDTH-1:0] r_sr [c_D];
      // Lane c is held back N-1-c cycles to undo the array's column skew
      always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
          for (int i = 0; i < c_D; i++) r_sr[i] <= '0;
        end else begin
          r_sr[0] <= bus.psum_i[c*ACC_WIDTH +: ACC_WIDTH];
          for (int i = 1; i < c_D; i++) r_sr[i] <= r_sr[i-1];
        end
      end
      assign w_aligned[c*ACC_WIDTH +: ACC_WIDTH] = r_sr[c_D-1];
    end
    // First tile overwrites; later tiles add with natural wrap-around
    assign w_acc_new[c*ACC_WIDTH +: ACC_WIDTH] = w_al.first ?
        w_aligned[c*ACC_WIDTH +: ACC_WIDTH] :
        w_acc_cur[c*ACC_WIDTH +: ACC_WIDTH] + w_aligned[c*ACC_WIDTH +: ACC_WIDTH];
  end

  // Accumulator bank: one row written per aligned vector, others retained
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int r = 0; r < ROWS; r++) r_acc[r] <= '0;
    end else if (w_al.vld) begin
      r_acc[w_al.row] <= w_acc_new;
    end
  end

  assign w_full     = (r_count == c_FULL);
  assign w_pop      = (r_count != '0) && bus.out_ready_i;
  assign w_push_req = w_al.vld && w_al.last;
  // A simultaneous pop frees a slot, so a full FIFO still accepts the push
  assign w_push     = w_push_req && (!w_full || w_pop);
  assign w_drop     = w_push_req && w_full && !w_pop;

  // Output FIFO storage, pointers, occupancy and sticky overflow flag
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < FIFO_DEPTH; i++) r_fifo[i] <= '0;
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
      r_ovf   <= 1'b0;
    end else begin
      if (w_push) begin
        r_fifo[r_wptr] <= w_acc_new;
        r_wptr         <= r_wptr + c_PW'(1);
      end
      if (w_pop) r_rptr <= r_rptr + c_PW'(1);
      if (w_push && !w_pop)      r_count <= r_count + c_CW'(1);
      else if (!w_push && w_pop) r_count <= r_count - c_CW'(1);
      if (w_drop) r_ovf <= 1'b1;
    end
  end

  assign bus.out_valid_o = (r_count != '0);
  assign bus.out_data_o  = r_fifo[r_rptr];
  assign overflow_o      = r_ovf;
  assign busy_o          = w_pipe_any || (r_count != '0);

endmodule
`default_nettype wire

// File: tb/tb_sysray_deskew_acc.sv
`default_nettype none
// ============================================================================
// Module      : tb_sysray_deskew_acc
// Description : Self-checking bench for sysray_deskew_acc. Stimulus applies
//               the column skew; a monitor pops expected rows from a queue
//               whenever an output handshake completes.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sysray_deskew_acc;

  localparam int N    = 4;
  localparam int W    = 32;
  localparam int ROWS = 16;
  localparam int FD   = 4;
  localparam int VW   = N * W;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  logic busy;
  logic ovf;

  sysray_deskew_acc_if #(.N(N), .ACC_WIDTH(W), .ROWS(ROWS)) bus ();

  sysray_deskew_acc #(.N(N), .ACC_WIDTH(W), .ROWS(ROWS), .FIFO_DEPTH(FD)) dut (
    .clk_i      (clk),
    .rst_ni     (rst_n),
    .bus        (bus),
    .busy_o     (busy),
    .overflow_o (ovf)
  );

  always #5 clk = ~clk;

  int          n_cmp = 0;
  int          n_err = 0;
  logic [VW-1:0] exp_q [$];
  logic [VW-1:0] hist [N];
  logic [VW-1:0] mon_exp;

  function automatic logic [VW-1:0] mk(input logic [W-1:0] a, b, c, d);
    return {d, c, b, a};
  endfunction

  task automatic chk(input string name, input logic [VW-1:0] act, input logic [VW-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Scoreboard monitor: every accepted output must match the queue head
  always @(negedge clk) begin
    if (rst_n && bus.out_valid_o && bus.out_ready_i) begin
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL unexpected_output: actual=%0h required=none", bus.out_data_o);
      end else begin
        mon_exp = exp_q.pop_front();
        if (bus.out_data_o !== mon_exp) begin
          n_err++;
          $display("FAIL out_row: actual=%0h required=%0h", bus.out_data_o, mon_exp);
        end
      end
    end
  end

  // One clock of stimulus; lane c carries the vector issued c cycles earlier
  task automatic step(input logic v, input logic [3:0] row, input logic f, input logic l,
                      input logic [VW-1:0] vec, input logic rdy);
    logic [VW-1:0] p;
    @(posedge clk); #1;
    for (int i = N-1; i > 0; i--) hist[i] = hist[i-1];
    hist[0] = v ? vec : '0;
    for (int c = 0; c < N; c++) p[c*W +: W] = hist[c][c*W +: W];
    bus.psum_i       = p;
    bus.psum_valid_i = v;
    bus.row_i        = row;
    bus.first_i      = f;
    bus.last_i       = l;
    bus.out_ready_i  = rdy;
  endtask

  task automatic idle(input int n, input logic rdy);
    for (int i = 0; i < n; i++) step(1'b0, 4'd0, 1'b0, 1'b0, '0, rdy);
  endtask

  task automatic clear_inputs();
    for (int i = 0; i < N; i++) hist[i] = '0;
    bus.psum_i       = '0;
    bus.psum_valid_i = 1'b0;
    bus.row_i        = '0;
    bus.first_i      = 1'b0;
    bus.last_i       = 1'b0;
    bus.out_ready_i  = 1'b0;
  endtask

  task automatic do_reset();
    @(posedge clk); #2;
    rst_n = 1'b0;
    clear_inputs();
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  initial begin
    clear_inputs();
    #1 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_valid", bus.out_valid_o, 0);
    chk("rst_out_data",  bus.out_data_o,  0);
    chk("rst_busy",      busy, 0);
    chk("rst_overflow",  ovf,  0);
    rst_n = 1'b1;

    // Single vector, first & last, latency N
    step(1, 0, 1, 1, mk(10, 20, 30, 40), 1);
    exp_q.push_back(mk(10, 20, 30, 40));
    idle(3, 1);
    @(negedge clk); chk("t1_no_early_valid", bus.out_valid_o, 0);
    idle(1, 1);
    @(negedge clk); chk("t1_valid_at_T4", bus.out_valid_o, 1);
    idle(1, 1);
    @(negedge clk); chk("t1_valid_one_cycle", bus.out_valid_o, 0);
    chk("t1_busy_low", busy, 0);

    // K=3 accumulation on row 5, back-to-back on the same row
    step(1, 5, 1, 0, mk(1, 1, 1, 1), 1);
    step(1, 5, 0, 0, mk(2, 2, 2, 2), 1);
    step(1, 5, 0, 1, mk(3, 3, 3, 3), 1);
    exp_q.push_back(mk(6, 6, 6, 6));
    idle(8, 1);
    @(negedge clk); chk("t2_busy_low", busy, 0);

    // Wrap-around addition
    step(1, 2, 1, 0, mk(32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF), 1);
    step(1, 2, 0, 1, mk(1, 1, 1, 1), 1);
    exp_q.push_back(mk(0, 0, 0, 0));
    idle(8, 1);
    @(negedge clk); chk("t3_overflow_low", ovf, 0);

    // Backpressure: five finished rows into a four-deep FIFO
    for (int k = 0; k < 5; k++) begin
      step(1, 4'(k), 1, 1, mk(100+k, 110+k, 120+k, 130+k), 0);
      if (k < 4) exp_q.push_back(mk(100+k, 110+k, 120+k, 130+k));
    end
    idle(6, 0);
    @(negedge clk);
    chk("t4_valid_held", bus.out_valid_o, 1);
    chk("t4_overflow_set", ovf, 1);
    chk("t4_head", bus.out_data_o, mk(100, 110, 120, 130));
    idle(2, 0);
    @(negedge clk); chk("t4_head_stable", bus.out_data_o, mk(100, 110, 120, 130));
    idle(8, 1);
    @(negedge clk);
    chk("t4_drained", exp_q.size(), 0);
    chk("t4_overflow_sticky", ovf, 1);
    chk("t4_busy_low", busy, 0);

    // Full FIFO with push and pop on the same edge
    do_reset();
    for (int k = 0; k < 4; k++) begin
      step(1, 4'(k), 1, 1, mk(200+k, 210+k, 220+k, 230+k), 0);
      exp_q.push_back(mk(200+k, 210+k, 220+k, 230+k));
    end
    idle(6, 0);
    step(1, 4, 1, 1, mk(204, 214, 224, 234), 0);
    exp_q.push_back(mk(204, 214, 224, 234));
    idle(2, 0);
    idle(1, 1);
    idle(1, 0);
    @(negedge clk);
    chk("t5_valid", bus.out_valid_o, 1);
    chk("t5_overflow_low", ovf, 0);
    chk("t5_head_after_pop", bus.out_data_o, mk(201, 211, 221, 231));
    idle(10, 1);
    @(negedge clk);
    chk("t5_drained", exp_q.size(), 0);
    chk("t5_overflow_still_low", ovf, 0);

    // Asynchronous reset with data in the pipe and in the FIFO
    do_reset();
    for (int k = 0; k < 3; k++) step(1, 4'(k), 1, 1, mk(300+k, 1, 2, 3), 0);
    idle(6, 0);
    step(1, 3, 1, 1, mk(400, 401, 402, 403), 0);
    step(1, 4, 1, 1, mk(500, 501, 502, 503), 0);
    idle(1, 0);
    @(negedge clk);
    chk("t6_pre_valid", bus.out_valid_o, 1);
    chk("t6_pre_busy", busy, 1);
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    chk("t6_rst_valid", bus.out_valid_o, 0);
    chk("t6_rst_data", bus.out_data_o, 0);
    chk("t6_rst_busy", busy, 0);
    chk("t6_rst_overflow", ovf, 0);
    clear_inputs();
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    idle(12, 1);
    @(negedge clk);
    chk("t6_post_busy", busy, 0);
    chk("t6_post_valid", bus.out_valid_o, 0);

    chk("final_queue_empty", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
